// File: rtl/tx_uart_framer.sv
// Byte FIFO plus UART 8N1 burst transmitter: start_tx drains the whole FIFO as LSB-first frames.
// First start bit 2 cycles after start_tx; writes to a full FIFO are dropped and flagged, no stall.
module tx_uart_framer #(
  parameter int DEPTH    = 64,
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_tx,
  input  logic       wren_fifo_tx,
  input  logic       start_tx,
  output logic       ready_tx,
  output logic [7:0] size_fifo_tx,
  output logic       overflow,
  output logic       tx_done,
  output logic       tx_serial
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE   = LW'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          overflow_q, overflow_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          serial_q, serial_d;

  logic pop;
  logic push;
  logic start_ok;
  logic baud_end;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign pop      = (state_q == S_LOAD);
  assign push     = wren_fifo_tx && ((level_q != FULL_LEVEL) || pop);
  assign start_ok = (state_q == S_IDLE) && start_tx && (level_q != '0);
  assign baud_end = (baud_q == '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    if (start_ok) begin
      overflow_d = 1'b0;
    end
    if (wren_fifo_tx && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d   = mem_q[rd_ptr_q];
        bit_cnt_d = '0;
        baud_d    = BAUD_RELOAD;
        state_d   = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = BAUD_RELOAD;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = BAUD_RELOAD;
          state_d = (level_q != '0) ? S_LOAD : S_IDLE;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are a registered view of the current state, so every output lags the FSM by one cycle.
  always_comb begin
    ready_d  = (state_q == S_IDLE);
    done_d   = (state_q == S_IDLE) && !ready_q;
    serial_d = 1'b1;
    if (state_q == S_START) begin
      serial_d = 1'b0;
    end else if (state_q == S_DATA) begin
      serial_d = shift_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_tx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_q     <= BAUD_RELOAD;
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      serial_q   <= serial_d;
    end
  end

  assign ready_tx     = ready_q;
  assign size_fifo_tx = 8'(level_q);
  assign overflow     = overflow_q;
  assign tx_done      = done_q;
  assign tx_serial    = serial_q;

endmodule

// File: tb/tb_tx_uart_framer.sv
// Bench for tx_uart_framer: queue-based FIFO model plus an ideal 8N1 line model, randomized payloads.
module tb_tx_uart_framer;

  localparam int DEPTH    = 8;
  localparam int BAUD_DIV = 4;
  localparam int FRAME    = 10 * BAUD_DIV + 1;

  typedef logic [7:0] byte_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_tx;
  logic       wren_fifo_tx;
  logic       start_tx;
  logic       ready_tx;
  logic [7:0] size_fifo_tx;
  logic       overflow;
  logic       tx_done;
  logic       tx_serial;

  int n_checks = 0;
  int n_fail   = 0;

  byte_t model_fifo[$];
  logic  model_ovf;
  logic  exp_line[$];

  logic  got_line[$];
  logic  got_rdy[$];
  logic  got_done[$];
  logic  got_ovf[$];
  byte_t got_size[$];

  tx_uart_framer #(
    .DEPTH    (DEPTH),
    .BAUD_DIV (BAUD_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_tx      (data_tx),
    .wren_fifo_tx (wren_fifo_tx),
    .start_tx     (start_tx),
    .ready_tx     (ready_tx),
    .size_fifo_tx (size_fifo_tx),
    .overflow     (overflow),
    .tx_done      (tx_done),
    .tx_serial    (tx_serial)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    wren_fifo_tx = 1'b0;
    start_tx     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_fifo.delete();
    model_ovf = 1'b0;
  endtask

  // Leaves wren high; the next driving step deasserts it, so consecutive calls write back to back.
  task automatic write_byte(input byte_t b);
    @(negedge clk);
    data_tx      = b;
    wren_fifo_tx = 1'b1;
    if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    wren_fifo_tx = 1'b0;
    start_tx     = 1'b0;
  endtask

  // Ideal line: per byte, one high LOAD cycle then start, 8 data bits LSB first, stop.
  task automatic model_burst(output int t);
    byte_t b;
    exp_line.delete();
    while (model_fifo.size() > 0) begin
      b = model_fifo.pop_front();
      exp_line.push_back(1'b1);
      repeat (BAUD_DIV) exp_line.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (BAUD_DIV) exp_line.push_back(b[i]);
      repeat (BAUD_DIV) exp_line.push_back(1'b1);
    end
    t = exp_line.size();
    model_ovf = 1'b0;
  endtask

  // Entry m holds outputs after the m-th edge following the edge that samples start_tx.
  task automatic record_burst(input int n, input bit inj, input byte_t inj_b);
    got_line.delete(); got_rdy.delete(); got_done.delete();
    got_ovf.delete();  got_size.delete();
    @(negedge clk);
    wren_fifo_tx = 1'b0;
    start_tx     = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start_tx     = 1'b0;
      wren_fifo_tx = 1'b0;
      got_line.push_back(tx_serial);
      got_rdy.push_back(ready_tx);
      got_done.push_back(tx_done);
      got_ovf.push_back(overflow);
      got_size.push_back(size_fifo_tx);
      if (inj && k == 1) begin
        data_tx      = inj_b;
        wren_fifo_tx = 1'b1;
      end
    end
    wren_fifo_tx = 1'b0;
  endtask

  function automatic int line_diffs(input int t);
    int bad = 0;
    for (int m = 0; m < t + 3; m++) begin
      if (m >= got_line.size()) bad++;
      else if (got_line[m] !== ((m >= 1 && m <= t) ? exp_line[m-1] : 1'b1)) bad++;
    end
    return bad;
  endfunction

  function automatic int rdy_diffs(input int t);
    int bad = 0;
    for (int m = 0; m < t + 3; m++) begin
      if (m >= got_rdy.size()) bad++;
      else if (got_rdy[m] !== !(m >= 1 && m <= t)) bad++;
    end
    return bad;
  endfunction

  function automatic int done_diffs(input int t);
    int bad = 0;
    for (int m = 0; m < t + 3; m++) begin
      if (m >= got_done.size()) bad++;
      else if (got_done[m] !== (m == t + 1)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset_tx_serial got=%b exp=1", tx_serial); end
    n_checks++; if (ready_tx !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_tx); end
    n_checks++; if (size_fifo_tx !== 8'd0) begin n_fail++; $display("FAIL reset_size got=%0d exp=0", size_fifo_tx); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", tx_done); end
  endtask

  task automatic test_single_a5();
    int t, bad;
    write_byte(8'hA5);
    model_burst(t);
    record_burst(t + 3, 1'b0, 8'h00);
    n_checks++; if (got_line[1] !== 1'b1 || got_line[2] !== 1'b0) begin
      n_fail++; $display("FAIL a5_first_low got=%b%b exp=10", got_line[1], got_line[2]); end
    bad = line_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL a5_line bad_cycles=%0d exp=0", bad); end
    bad = rdy_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL a5_ready bad_cycles=%0d exp=0", bad); end
    bad = done_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL a5_done bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int t, bad, n0;
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
    n0 = model_fifo.size();
    model_burst(t);
    record_burst(t + 3, 1'b0, 8'h00);
    for (int f = 0; f < n0; f++) begin
      n_checks++; if (got_size[f*FRAME] !== byte_t'(n0 - f)) begin
        n_fail++; $display("FAIL b2b_size_before_load%0d got=%0d exp=%0d", f, got_size[f*FRAME], n0 - f); end
      n_checks++; if (got_size[f*FRAME+1] !== byte_t'(n0 - f - 1)) begin
        n_fail++; $display("FAIL b2b_size_after_load%0d got=%0d exp=%0d", f, got_size[f*FRAME+1], n0 - f - 1); end
    end
    bad = line_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_line bad_cycles=%0d exp=0", bad); end
    bad = rdy_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_ready bad_cycles=%0d exp=0", bad); end
    bad = done_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_done bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_random_burst();
    int t, bad, n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_byte(byte_t'($urandom_range(0, 255)));
      idle_cycle();
      n_checks++; if (size_fifo_tx !== byte_t'(model_fifo.size())) begin
        n_fail++; $display("FAIL rand%0d_size got=%0d exp=%0d", r, size_fifo_tx, model_fifo.size()); end
      model_burst(t);
      record_burst(t + 3, 1'b0, 8'h00);
      bad = line_diffs(t);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_line bad_cycles=%0d exp=0", r, bad); end
      bad = done_diffs(t);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_done bad_cycles=%0d exp=0", r, bad); end
    end
  endtask

  task automatic test_overflow();
    int t, bad;
    logic exp_ovf;
    for (int i = 0; i < DEPTH + 2; i++) write_byte(byte_t'($urandom_range(0, 255)));
    idle_cycle();
    exp_ovf = model_ovf;
    n_checks++; if (size_fifo_tx !== byte_t'(model_fifo.size())) begin
      n_fail++; $display("FAIL ovf_size got=%0d exp=%0d", size_fifo_tx, model_fifo.size()); end
    n_checks++; if (overflow !== exp_ovf) begin
      n_fail++; $display("FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf); end
    model_burst(t);
    record_burst(t + 3, 1'b0, 8'h00);
    n_checks++; if (got_ovf[0] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear_on_start got=%b exp=0", got_ovf[0]); end
    bad = line_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ovf_line bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_empty_start();
    int bad = 0;
    @(negedge clk);
    start_tx = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_tx = 1'b0;
      if (ready_tx !== 1'b1 || tx_serial !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL empty_start bad_cycles=%0d exp=0", bad); end
    n_checks++; if (size_fifo_tx !== 8'd0) begin n_fail++; $display("FAIL empty_size got=%0d exp=0", size_fifo_tx); end
  endtask

  task automatic test_load_write();
    int t, bad;
    byte_t extra;
    for (int i = 0; i < DEPTH; i++) write_byte(byte_t'($urandom_range(0, 255)));
    idle_cycle();
    n_checks++; if (size_fifo_tx !== byte_t'(DEPTH) || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_pre size=%0d ovf=%b exp size=%0d ovf=0", size_fifo_tx, overflow, DEPTH); end
    extra = byte_t'($urandom_range(0, 255));
    model_fifo.push_back(extra);
    model_burst(t);
    record_burst(t + 3, 1'b1, extra);
    n_checks++; if (got_size[1] !== byte_t'(DEPTH)) begin
      n_fail++; $display("FAIL load_write_size got=%0d exp=%0d", got_size[1], DEPTH); end
    n_checks++; if (got_ovf[2] !== 1'b0) begin
      n_fail++; $display("FAIL load_write_ovf got=%b exp=0", got_ovf[2]); end
    bad = line_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL load_write_line bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    int t, bad;
    write_byte(8'h00); write_byte(8'h00);
    @(negedge clk);
    wren_fifo_tx = 1'b0;
    start_tx     = 1'b1;
    repeat (1 + 3 * BAUD_DIV) begin
      @(negedge clk);
      start_tx = 1'b0;
    end
    n_checks++; if (tx_serial !== 1'b0) begin n_fail++; $display("FAIL mid_data_bit got=%b exp=0", tx_serial); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_fifo.delete();
    model_ovf = 1'b0;
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL mid_reset_line got=%b exp=1", tx_serial); end
    n_checks++; if (ready_tx !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=1", ready_tx); end
    n_checks++; if (size_fifo_tx !== 8'd0) begin n_fail++; $display("FAIL mid_reset_size got=%0d exp=0", size_fifo_tx); end
    write_byte(byte_t'($urandom_range(0, 255)));
    model_burst(t);
    record_burst(t + 3, 1'b0, 8'h00);
    bad = line_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL post_reset_line bad_cycles=%0d exp=0", bad); end
    bad = done_diffs(t);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL post_reset_done bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    reset        = 1'b1;
    data_tx      = 8'h00;
    wren_fifo_tx = 1'b0;
    start_tx     = 1'b0;
    model_ovf    = 1'b0;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_random_burst();
    test_overflow();
    test_empty_start();
    test_load_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
